// File: rtl/frog_game_ctrl_pkg.sv
// Shared definitions for the frog game controller and renderer.
// One-hot state encoding so each state bit can drive a renderer input.
package frog_game_ctrl_pkg;

    localparam int HOP_FRAMES_DEF   = 16;
    localparam int DEATH_FRAMES_DEF = 128;
    localparam int SCORE_W_DEF      = 8;
    localparam int PHASE_W          = 5;

    typedef enum logic [7:0] {
        ST_IDLE  = 8'b0000_0001,
        ST_START = 8'b0000_0010,
        ST_GO    = 8'b0000_0100,
        ST_UP    = 8'b0000_1000,
        ST_CFU   = 8'b0001_0000,
        ST_DOWN  = 8'b0010_0000,
        ST_CFD   = 8'b0100_0000,
        ST_DEATH = 8'b1000_0000
    } state_e;

    function automatic logic in_play(input state_e s);
        return (s == ST_GO) || (s == ST_UP) || (s == ST_CFU) ||
               (s == ST_DOWN) || (s == ST_CFD);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Button front end: two-flop synchronizer followed by a rising-edge
// detector, giving one pulse per press however long it is held.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic s1_q, s2_q, dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            dly_q <= 1'b0;
        end else begin
            s1_q  <= btn_i;
            s2_q  <= s1_q;
            dly_q <= s2_q;
        end
    end

    assign pulse_o = s2_q & ~dly_q;

endmodule

// File: rtl/frog_game_ctrl.sv
// Frame-aligned game FSM: button presses, hop sequencing, lily-pad
// collision detection and hop score for the VGA frog renderer.
module frog_game_ctrl #(
    parameter int HOP_FRAMES   = 16,
    parameter int DEATH_FRAMES = 128,
    parameter int SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btnC,
    input  logic               btnU,
    input  logic               btnD,
    input  logic               frameBound,
    input  logic               collide,
    output logic               idle,
    output logic               start,
    output logic               go,
    output logic               up,
    output logic               down,
    output logic               center_fromUp,
    output logic               center_fromDown,
    output logic               death,
    output logic               blink,
    output logic [4:0]         hop_phase,
    output logic [SCORE_W-1:0] score
);

    import frog_game_ctrl_pkg::*;

    localparam int DW = $clog2(DEATH_FRAMES + 1);
    localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(HOP_FRAMES - 1);
    localparam logic [DW-1:0]      DC_LAST = DW'(DEATH_FRAMES - 1);

    logic pc, pu, pd;

    btn_edge u_btn_c (.clk(clk), .rst(rst), .btn_i(btnC), .pulse_o(pc));
    btn_edge u_btn_u (.clk(clk), .rst(rst), .btn_i(btnU), .pulse_o(pu));
    btn_edge u_btn_d (.clk(clk), .rst(rst), .btn_i(btnD), .pulse_o(pd));

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [DW-1:0]        dcnt_q, dcnt_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 p_start_q, p_start_d;
    logic                 p_up_q, p_up_d;
    logic                 p_down_q, p_down_d;
    logic                 hit_q, hit_d;
    logic                 hit_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            dcnt_q    <= '0;
            score_q   <= '0;
            p_start_q <= 1'b0;
            p_up_q    <= 1'b0;
            p_down_q  <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            dcnt_q    <= dcnt_d;
            score_q   <= score_d;
            p_start_q <= p_start_d;
            p_up_q    <= p_up_d;
            p_down_q  <= p_down_d;
            hit_q     <= hit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        dcnt_d    = dcnt_q;
        score_d   = score_q;
        p_start_d = 1'b0;
        p_up_d    = 1'b0;
        p_down_d  = 1'b0;
        // A collide on the tick cycle itself still counts for this tick.
        hit_now   = hit_q | (collide & in_play(state_q));
        hit_d     = frameBound ? 1'b0 : hit_now;

        unique case (state_q)
            ST_IDLE: begin
                p_start_d = p_start_q | pc;
                if (frameBound && p_start_q) begin
                    state_d   = ST_START;
                    p_start_d = 1'b0;
                    score_d   = '0;
                end
            end
            ST_START: begin
                if (frameBound) state_d = ST_GO;
            end
            ST_GO: begin
                p_up_d   = p_up_q | pu;
                p_down_d = p_down_q | pd;
                if (frameBound && (hit_now || p_up_q || p_down_q)) begin
                    p_up_d   = 1'b0;
                    p_down_d = 1'b0;
                    phase_d  = '0;
                    dcnt_d   = '0;
                    if (hit_now)     state_d = ST_DEATH;
                    else if (p_up_q) state_d = ST_UP;
                    else             state_d = ST_DOWN;
                end
            end
            ST_UP, ST_DOWN, ST_CFU, ST_CFD: begin
                if (frameBound) begin
                    if (hit_now) begin
                        state_d = ST_DEATH;
                        phase_d = '0;
                        dcnt_d  = '0;
                    end else if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        unique case (state_q)
                            ST_UP:   state_d = ST_CFU;
                            ST_DOWN: state_d = ST_CFD;
                            default: begin
                                state_d = ST_GO;
                                if (!(&score_q)) score_d = score_q + 1'b1;
                            end
                        endcase
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            ST_DEATH: begin
                if (frameBound) begin
                    if (dcnt_q == DC_LAST) begin
                        state_d = ST_IDLE;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idle            = state_q[0];
        start           = state_q[1];
        go              = state_q[2];
        up              = state_q[3];
        center_fromUp   = state_q[4];
        down            = state_q[5];
        center_fromDown = state_q[6];
        death           = state_q[7];
        blink           = state_q[7];
        hop_phase       = phase_q;
        score           = score_q;
    end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed bench for frog_game_ctrl: frame tick every 8 cycles,
// 4-frame hops and death, 2-bit score to reach saturation.
module tb_frog_game_ctrl;

    localparam logic [7:0] S_IDLE  = 8'b0000_0001;
    localparam logic [7:0] S_START = 8'b0000_0010;
    localparam logic [7:0] S_GO    = 8'b0000_0100;
    localparam logic [7:0] S_UP    = 8'b0000_1000;
    localparam logic [7:0] S_CFU   = 8'b0001_0000;
    localparam logic [7:0] S_DOWN  = 8'b0010_0000;
    localparam logic [7:0] S_CFD   = 8'b0100_0000;
    localparam logic [7:0] S_DEATH = 8'b1000_0000;

    logic clk = 1'b0;
    logic rst, btnC, btnU, btnD, frameBound, collide;
    logic idle, start, go, up, down, cfu, cfd, death, blink;
    logic [4:0] hop_phase;
    logic [1:0] score;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    frog_game_ctrl #(
        .HOP_FRAMES(4), .DEATH_FRAMES(4), .SCORE_W(2)
    ) dut (
        .clk(clk), .rst(rst),
        .btnC(btnC), .btnU(btnU), .btnD(btnD),
        .frameBound(frameBound), .collide(collide),
        .idle(idle), .start(start), .go(go), .up(up), .down(down),
        .center_fromUp(cfu), .center_fromDown(cfd), .death(death),
        .blink(blink), .hop_phase(hop_phase), .score(score)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] st();
        return {death, cfd, down, cfu, up, go, start, idle};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        frameBound = (cyc % 8 == 7);
    endtask

    task automatic wait_tick();
        int g = 0;
        while (!frameBound && g < 16) begin
            step();
            g++;
        end
        step();
    endtask

    task automatic press(input logic c, input logic u, input logic d);
        btnC = c; btnU = u; btnD = d;
        step();
        btnC = 1'b0; btnU = 1'b0; btnD = 1'b0;
    endtask

    task automatic hop(input logic dn, input int exp_sc);
        press(1'b0, ~dn, dn);
        for (int p = 0; p < 4; p++) begin
            wait_tick();
            check("hop_st", st(), dn ? S_DOWN : S_UP);
            check("hop_ph", hop_phase, p);
        end
        for (int p = 0; p < 4; p++) begin
            wait_tick();
            check("cf_st", st(), dn ? S_CFD : S_CFU);
            check("cf_ph", hop_phase, p);
        end
        wait_tick();
        check("hop_end_st", st(), S_GO);
        check("hop_end_sc", score, exp_sc);
        check("hop_end_ph", hop_phase, 0);
    endtask

    task automatic start_game();
        press(1'b1, 1'b0, 1'b0);
        wait_tick();
        check("start_st", st(), S_START);
        check("start_sc", score, 0);
        wait_tick();
        check("go_st", st(), S_GO);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; btnC = 1'b0; btnU = 1'b0; btnD = 1'b0;
        frameBound = 1'b0; collide = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_st", st(), S_IDLE);
        check("rst_sc", score, 0);
        check("rst_blink", blink, 0);
        check("rst_ph", hop_phase, 0);
        rst = 1'b0;
        cyc = 0;

        for (int i = 0; i < 10; i++) begin
            wait_tick();
            check("idle_hold", st(), S_IDLE);
        end

        start_game();
        hop(1'b0, 1);

        // Both buttons together: UP wins and DOWN is dropped.
        press(1'b0, 1'b1, 1'b1);
        wait_tick();
        check("both_up", st(), S_UP);
        for (int p = 1; p < 4; p++) wait_tick();
        for (int p = 0; p < 4; p++) wait_tick();
        wait_tick();
        check("both_go", st(), S_GO);
        check("both_sc", score, 2);
        wait_tick();
        check("no_down", st(), S_GO);

        press(1'b0, 1'b0, 1'b1);
        wait_tick();
        wait_tick();
        wait_tick();
        check("dn_ph2", hop_phase, 2);
        repeat (3) step();
        collide = 1'b1;
        step();
        collide = 1'b0;
        wait_tick();
        check("col_st", st(), S_DEATH);
        check("col_blink", blink, 1);
        check("col_sc", score, 2);
        for (int i = 0; i < 3; i++) begin
            wait_tick();
            check("death_hold", st(), S_DEATH);
        end
        wait_tick();
        check("death_end", st(), S_IDLE);
        check("death_sc", score, 2);
        check("death_blink", blink, 0);

        start_game();
        press(1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 8; p++) wait_tick();
        check("lastcfd_st", st(), S_CFD);
        check("lastcfd_ph", hop_phase, 3);
        while (!frameBound) step();
        collide = 1'b1;
        step();
        collide = 1'b0;
        check("tickcol_st", st(), S_DEATH);
        check("tickcol_sc", score, 0);
        for (int i = 0; i < 4; i++) wait_tick();
        check("tickcol_idle", st(), S_IDLE);

        start_game();
        btnU = 1'b1;
        for (int i = 0; i < 50; i++) wait_tick();
        check("held_st", st(), S_GO);
        check("held_sc", score, 1);
        btnU = 1'b0;
        wait_tick();
        check("held_rel", st(), S_GO);

        hop(1'b1, 2);
        hop(1'b0, 3);
        hop(1'b1, 3);
        hop(1'b0, 3);

        press(1'b0, 1'b1, 1'b0);
        wait_tick();
        wait_tick();
        check("mid_up_st", st(), S_UP);
        check("mid_up_ph", hop_phase, 1);
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_st", st(), S_IDLE);
        check("arst_sc", score, 0);
        check("arst_ph", hop_phase, 0);
        step();
        step();
        rst = 1'b0;
        wait_tick();
        check("post_rst", st(), S_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
